// File: rtl/gs_ddram_bridge.sv
// Byte-wide General Sound memory port to 64-bit single-beat DDR3 bridge.
// Define GS_DDRAM_CACHE_EN to add a one-line, write-through read cache.
module gs_ddram_bridge #(
  parameter int          ADDR_W     = 21,
  parameter logic [28:0] BASE_WADDR = 29'h0600_0000
) (
  input  logic              DDRAM_CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  input  logic              we,
  input  logic              rd,
  output logic              ready,
  input  logic              DDRAM_BUSY,
  output logic [7:0]        DDRAM_BURSTCNT,
  output logic [28:0]       DDRAM_ADDR,
  input  logic [63:0]       DDRAM_DOUT,
  input  logic              DDRAM_DOUT_READY,
  output logic              DDRAM_RD,
  output logic [63:0]       DDRAM_DIN,
  output logic [7:0]        DDRAM_BE,
  output logic              DDRAM_WE,
  output logic [1:0]        fsm_state
);

  // Handshake: a rising edge on we/rd starts one request while ready=1;
  // ready drops in that same cycle and rises again once it completes.
  // DDR side: RD/WE are held until a cycle with DDRAM_BUSY=0 accepts them.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR     = 2'd1,
    S_RD     = 2'd2,
    S_RDWAIT = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        old_rd, old_we;
  logic        wr_edge, rd_edge, rd_edge_miss;
  logic        cache_hit;
  logic [7:0]  cache_byte;
  logic        take_wr, take_rd, take_hit;
  logic [2:0]  lane;
  logic [28:0] waddr_q;
  logic [63:0] din_q;
  logic [7:0]  be_q;

  assign wr_edge      = we & ~old_we;
  assign rd_edge      = rd & ~old_rd;
  assign rd_edge_miss = rd_edge & ~cache_hit;

  // A write edge wins over a simultaneous read edge; that read is dropped.
  assign take_wr  = (state == S_IDLE) & wr_edge;
  assign take_rd  = (state == S_IDLE) & ~wr_edge & rd_edge_miss;
  assign take_hit = (state == S_IDLE) & ~wr_edge & rd_edge & cache_hit;

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      old_rd <= 1'b0;
      old_we <= 1'b0;
    end else begin
      old_rd <= rd;
      old_we <= we;
    end
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (take_wr)      state_next = S_WR;
        else if (take_rd) state_next = S_RD;
      end
      S_WR:     if (!DDRAM_BUSY)       state_next = S_IDLE;
      S_RD:     if (!DDRAM_BUSY)       state_next = S_RDWAIT;
      S_RDWAIT: if (DDRAM_DOUT_READY)  state_next = S_IDLE;
      default:                         state_next = S_IDLE;
    endcase
  end

  assign ready          = (state == S_IDLE) & ~wr_edge & ~rd_edge_miss;
  assign DDRAM_WE       = (state == S_WR);
  assign DDRAM_RD       = (state == S_RD);
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = waddr_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign fsm_state      = state;

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      waddr_q <= BASE_WADDR;
      din_q   <= 64'd0;
      be_q    <= 8'd0;
      lane    <= 3'd0;
    end else if (take_wr || take_rd) begin
      waddr_q <= BASE_WADDR + 29'(addr[ADDR_W-1:3]);
      lane    <= addr[2:0];
      be_q    <= take_wr ? (8'd1 << addr[2:0]) : 8'hFF;
      if (take_wr) din_q <= {8{din}};
    end
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (reset)
      dout <= 8'hFF;
    else if (state == S_RDWAIT && DDRAM_DOUT_READY)
      dout <= DDRAM_DOUT[{lane, 3'b000} +: 8];
    else if (take_hit)
      dout <= cache_byte;
  end

`ifdef GS_DDRAM_CACHE_EN
  logic [63:0]       line;
  logic [ADDR_W-4:0] line_tag;
  logic [ADDR_W-4:0] tag_q;
  logic              line_valid;

  assign cache_hit  = line_valid & (line_tag == addr[ADDR_W-1:3]);
  assign cache_byte = line[{addr[2:0], 3'b000} +: 8];

  always_ff @(posedge DDRAM_CLK) begin
    if (reset)        tag_q <= '0;
    else if (take_rd) tag_q <= addr[ADDR_W-1:3];
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (reset)
      line_valid <= 1'b0;
    else if (state == S_RDWAIT && DDRAM_DOUT_READY)
      line_valid <= 1'b1;
  end

  // Writes that hit the line patch it so later hits see the new byte.
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      line     <= 64'd0;
      line_tag <= '0;
    end else if (state == S_RDWAIT && DDRAM_DOUT_READY) begin
      line     <= DDRAM_DOUT;
      line_tag <= tag_q;
    end else if (take_wr && cache_hit) begin
      line[{addr[2:0], 3'b000} +: 8] <= din;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_byte = 8'hFF;
`endif

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Scoreboard bench for gs_ddram_bridge with a small DDR memory model;
// expectations adapt to whether GS_DDRAM_CACHE_EN is defined.
module tb_gs_ddram_bridge;

`ifdef GS_DDRAM_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [20:0] gs_addr;
  logic [7:0]  gs_din;
  logic [7:0]  dout;
  logic        gs_we, gs_rd;
  logic        ready;
  logic        busy;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] ddr_dout;
  logic        ddr_rdy;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  logic [100:0] wr_q[$];
  logic [28:0]  rc_q[$];
  logic [7:0]   rd_q[$];
  logic [63:0]  mem [logic [28:0]];

  gs_ddram_bridge dut (
    .DDRAM_CLK        (clk),
    .reset            (reset),
    .addr             (gs_addr),
    .din              (gs_din),
    .dout             (dout),
    .we               (gs_we),
    .rd               (gs_rd),
    .ready            (ready),
    .DDRAM_BUSY       (busy),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DOUT       (ddr_dout),
    .DDRAM_DOUT_READY (ddr_rdy),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE),
    .fsm_state        (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_err(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // DDR memory model: 3-cycle read latency after command acceptance
  initial begin : ddr_model
    logic [28:0] a;
    logic [63:0] w;
    ddr_dout = 64'd0;
    ddr_rdy  = 1'b0;
    mem[29'h0600_0002] = 64'h8877_6655_4433_2211;
    forever begin
      @(negedge clk);
      if (DDRAM_WE && !busy) begin
        a = DDRAM_ADDR;
        w = mem.exists(a) ? mem[a] : 64'd0;
        for (int b = 0; b < 8; b++)
          if (DDRAM_BE[b]) w[8*b +: 8] = DDRAM_DIN[8*b +: 8];
        mem[a] = w;
      end
      if (DDRAM_RD && !busy) begin
        a = DDRAM_ADDR;
        repeat (3) @(posedge clk);
        #1;
        ddr_dout = mem.exists(a) ? mem[a] : 64'd0;
        ddr_rdy  = 1'b1;
        @(posedge clk);
        #1;
        ddr_rdy  = 1'b0;
      end
    end
  end

  // monitors
  initial begin : mon_wr
    logic [100:0] e;
    forever begin
      @(negedge clk);
      if (!reset && DDRAM_WE && !busy) begin
        if (wr_q.size() == 0) flag_err("unexpected_ddram_we");
        else begin
          e = wr_q.pop_front();
          check("wr_addr", {35'd0, DDRAM_ADDR}, {35'd0, e[100:72]});
          check("wr_be",   {56'd0, DDRAM_BE},   {56'd0, e[71:64]});
          check("wr_din",  DDRAM_DIN,           e[63:0]);
        end
      end
    end
  end

  initial begin : mon_rdcmd
    logic [28:0] e;
    forever begin
      @(negedge clk);
      if (!reset && DDRAM_RD && !busy) begin
        if (rc_q.size() == 0) flag_err("unexpected_ddram_rd");
        else begin
          e = rc_q.pop_front();
          check("rd_addr", {35'd0, DDRAM_ADDR}, {35'd0, e});
          check("rd_be",   {56'd0, DDRAM_BE},   64'hFF);
        end
      end
    end
  end

  initial begin : mon_rddata
    logic       rd_prev, we_prev, got;
    logic [7:0] e;
    rd_prev = 1'b0;
    we_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && gs_rd && !rd_prev && !(gs_we && !we_prev) && fsm_state == 2'd0) begin
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (ready) begin
            got = 1'b1;
            break;
          end
        end
        if (rd_q.size() == 0) flag_err("unexpected_read_done");
        else begin
          e = rd_q.pop_front();
          if (!got) flag_err("rd_timeout");
          else check("rd_dout", {56'd0, dout}, {56'd0, e});
        end
      end
      rd_prev = gs_rd;
      we_prev = gs_we;
    end
  end

  // driver tasks
  task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int nb,
                          input bit with_rd, input logic [28:0] ew, input logic [7:0] ebe);
    int we_cnt;
    int low_cnt;
    bit done;
    wr_q.push_back({ew, ebe, {8{d}}});
    @(posedge clk); #1;
    gs_addr = a; gs_din = d; gs_we = 1'b1; gs_rd = with_rd; busy = (nb > 0);
    @(negedge clk);
    check("wr_ready_edge", {63'd0, ready}, 64'd0);
    we_cnt = 0; low_cnt = 1; done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      gs_we = 1'b0; gs_rd = 1'b0; busy = (k <= nb);
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
        break;
      end
      low_cnt++;
      if (DDRAM_WE) we_cnt++;
    end
    busy = 1'b0;
    if (!done) flag_err("wr_timeout");
    check("wr_we_cycles", 64'(we_cnt),  64'(nb + 1));
    check("wr_ready_low", 64'(low_cnt), 64'(nb + 2));
    check("wr_we_after",  {63'd0, DDRAM_WE}, 64'd0);
  endtask

  task automatic do_read(input logic [20:0] a, input logic [7:0] exp_d,
                         input bit miss, input logic [28:0] ew);
    int low_cnt;
    bit done;
    rd_q.push_back(exp_d);
    if (miss) rc_q.push_back(ew);
    @(posedge clk); #1;
    gs_addr = a; gs_rd = 1'b1;
    @(negedge clk);
    check("rd_ready_edge", {63'd0, ready}, miss ? 64'd0 : 64'd1);
    low_cnt = miss ? 1 : 0;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      gs_rd = 1'b0;
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
        break;
      end
      low_cnt++;
    end
    if (!done) flag_err("rd_ready_timeout");
    check("rd_ready_low", 64'(low_cnt), miss ? 64'd5 : 64'd0);
  endtask

  // stimulus
  initial begin
    reset = 1'b1; gs_addr = '0; gs_din = '0; gs_we = 1'b0; gs_rd = 1'b0; busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, ready},    64'd1);
    check("rst_rd",    {63'd0, DDRAM_RD}, 64'd0);
    check("rst_we",    {63'd0, DDRAM_WE}, 64'd0);
    check("rst_dout",  {56'd0, dout},     64'hFF);
    check("burstcnt",  {56'd0, DDRAM_BURSTCNT}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    do_write(21'h00005, 8'hA5, 0, 1'b0, 29'h0600_0000, 8'h20);
    do_write(21'h00005, 8'hA5, 3, 1'b0, 29'h0600_0000, 8'h20);
    do_read(21'h00013, 8'h44, 1'b1, 29'h0600_0002);
    do_read(21'h00017, 8'h88, !CACHE, 29'h0600_0002);
    do_write(21'h00010, 8'h5A, 0, 1'b0, 29'h0600_0002, 8'h01);
    do_read(21'h00010, 8'h5A, !CACHE, 29'h0600_0002);
    do_write(21'h00008, 8'hC3, 0, 1'b1, 29'h0600_0001, 8'h01);
    do_read(21'h00008, 8'hC3, 1'b1, 29'h0600_0001);

    // reset while waiting for DDR read data: the late data must be dropped
    rd_q.push_back(8'hFF);
    rc_q.push_back(29'h0600_0002);
    @(posedge clk); #1; gs_addr = 21'h00017; gs_rd = 1'b1;
    @(posedge clk); #1; gs_rd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_dout",  {56'd0, dout},     64'hFF);
    check("abort_ready", {63'd0, ready},    64'd1);
    check("abort_rd",    {63'd0, DDRAM_RD}, 64'd0);

    do_read(21'h00017, 8'h88, 1'b1, 29'h0600_0002);
    do_read(21'h00017, 8'h88, !CACHE, 29'h0600_0002);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("rc_q_empty", 64'(rc_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
